bitfusion_column_ctrl: RTL and testbench
========================================

# bitfusion_column_ctrl

Sequencing controller for one BitFusion PE column. It latches a job configuration: bit-width, sign modes and vector count. It then steps the column through three phases, drives the global column controls, and gates streamed activations. Those controls are `state`, `input_bitwidth`, `sign_x`, `sign_y` and the 48-bit fusion `signal`. The block tracks pipeline drain through the 16 chained PE registers and the accumulator, and flags when `total_output` holds the final sum.

## Interface
Parameters:
- `NUM_PE`, 16: PEs chained in the column (pipeline depth).
- `CNT_W`, 16: width of the vector counter.
- `WLOAD_LAT`, 2: cycles from weight presentation to valid `sorted_weight` (WBUF + MUX_REG).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request, sampled in IDLE only.
- `cfg_bitwidth`  in  2  job bit-width code, latched on start.
- `cfg_sign_x`  in  4  activation sign modes, latched on start.
- `cfg_sign_y`  in  4  weight sign modes, latched on start.
- `cfg_num_vec`  in  CNT_W  input vectors in the job, latched on start.
- `in_valid`  in  1  upstream activation beat available.
- `in_ready`  out  1  controller accepts beat (STREAM only).
- `in_fire`  out  1  `in_valid & in_ready`; gates sorted inputs to zero when low.
- `state`  out  2  column phase to Weight_MUX_REG: 00 idle, 01 load, 10 compute, 11 drain.
- `input_bitwidth`  out  2  latched bit-width.
- `sign_x`, `sign_y`  out  4 each  latched sign modes.
- `signal`  out  48  fusion control word, `BF_SIGNAL_LUT[input_bitwidth]`.
- `acc_clear`  out  1  one-cycle clear pulse to the accumulator.
- `busy`  out  1  high in every state except IDLE.
- `out_valid`  out  1  one-cycle pulse: `total_output` is final.
- `done`  out  1  one-cycle job-complete pulse.

## Operation
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- **IDLE:** on `start`, latch all `cfg_*`.
  - If `cfg_num_vec == 0`: go to DONE with no `out_valid`.
  - Otherwise: go to LOAD_W and pulse `acc_clear`.
- **LOAD_W:** `state = 01` for `WLOAD_LAT` cycles, then STREAM.
- **STREAM:** `state = 10`, `in_ready = 1`.
  - Each `in_fire` decrements the remaining count.
  - Cycles with `in_valid` low are bubbles. `in_fire = 0` zeroes that cycle's inputs, so the accumulator adds 0.
  - After the last beat is accepted, go to DRAIN.
- **DRAIN:** `state = 11` for `NUM_PE + 1` cycles. `out_valid` pulses in the last DRAIN cycle, then go to DONE.
- **DONE:** `done = 1` for one cycle, then IDLE.
- `start` while `busy` is ignored. `cfg_*` changes while `busy` are ignored.
- `signal` is derived combinationally from the latched bit-width through the package LUT. Unused codes map to the 8-bit entry.
- Counter: loaded with `cfg_num_vec`. It is decremented only on `in_fire` and never wraps below 0.
- The DRAIN counter is `$clog2(NUM_PE+2)` bits wide.

## Timing
- Reset values: all outputs 0; `state = 00`; `signal = BF_SIGNAL_LUT[0]`; FSM in IDLE.
- Reset asserted mid-job: immediate return to IDLE. No `done` and no `out_valid` are issued.
- Start accepted at cycle 0:
  - `acc_clear` is high in cycle 1.
  - LOAD_W occupies cycles 1..`WLOAD_LAT`.
  - The first beat can be accepted at cycle `WLOAD_LAT + 1`.
- Last beat accepted at cycle t:
  - DRAIN occupies t+1 .. t+`NUM_PE`+1.
  - `out_valid` fires at t+`NUM_PE`+1.
  - `done` fires at t+`NUM_PE`+2.
- `in_ready` is registered: it is high for every STREAM cycle and drops the cycle after the final beat is accepted.
- Outputs `state`, `input_bitwidth`, `sign_*`, `acc_clear`, `out_valid` and `done` are registered. `in_fire` and `signal` are combinational from registered values and `in_valid`.

## Configuration
- `BFC_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - In any busy state, `abort` returns the FSM to IDLE on the next edge.
  - `in_ready` and `busy` drop in that same cycle, and no `out_valid` or `done` is issued.
  - `abort` in IDLE has no effect.
- `BFC_ABORT_EN` undefined: the port is absent, and a job can only end through DONE or reset.

## Structure
- Shared package `bitfusion_pkg`:
  - Column-state codes (`BF_ST_IDLE`/`LOAD`/`COMP`/`DRAIN`).
  - Bit-width codes (2, 4, 8 bit).
  - `BF_SIGNAL_LUT` 48-bit constants.
  - `BF_NUM_PE` default.
- One sub-module, `bitfusion_beat_counter`: a loadable down-counter with a zero flag. It is instantiated twice, once for vectors and once for drain.

## Test plan
- **Basic job, no bubbles:** bitwidth = 8-bit, `num_vec = 4`, `in_valid` held high, `WLOAD_LAT = 2`, start at cycle 0 → `acc_clear` at cycle 1, beats accepted at cycles 3–6, `out_valid` at cycle 23, `done` at cycle 24, `busy` low at cycle 25.
- **Bubbles:** `num_vec = 3` with `in_valid` pattern 1,0,0,1,1 → exactly 3 `in_fire` cycles, DRAIN starts the cycle after the 5th STREAM cycle, `out_valid` 17 cycles after the last beat.
- **Zero-length job:** `num_vec = 0` → `done` at cycle 1, no `acc_clear`, no `out_valid`, `state` stays 00.
- **Config isolation:** `start` and changed `cfg_bitwidth` (2-bit) pulsed during STREAM → ignored; `input_bitwidth`, `sign_*` and `signal` hold the values latched at start throughout the job.
- **Reset mid-job:** `reset` low during DRAIN → all outputs 0 asynchronously; after release, a new `num_vec = 1` job completes normally.
- **Abort (`BFC_ABORT_EN`):** `abort` at cycle 4 of a 4-vector job → IDLE at cycle 5, no `done`/`out_valid`; a subsequent job runs with correct timing.

Source files
------------

// File: rtl/bitfusion_pkg.sv
// bitfusion_pkg: shared column-state codes, bit-width codes, fusion-signal LUT and FSM encoding.
package bitfusion_pkg;
  localparam int BF_NUM_PE = 16;
  typedef enum logic [1:0] {
    BF_ST_IDLE  = 2'b00,
    BF_ST_LOAD  = 2'b01,
    BF_ST_COMP  = 2'b10,
    BF_ST_DRAIN = 2'b11
  } bf_col_st_e;
  typedef enum logic [1:0] {
    BF_BW_2 = 2'd0,
    BF_BW_4 = 2'd1,
    BF_BW_8 = 2'd2
  } bf_bw_e;
  // Indexed by bit-width code; the unused code 3 reuses the 8-bit word.
  localparam logic [3:0][47:0] BF_SIGNAL_LUT = {
    48'hFFFF_FFFF_FFFF,
    48'hFFFF_FFFF_FFFF,
    48'h5555_5555_5555,
    48'h0000_0000_0000
  };
  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} bfc_fsm_e;
endpackage

// File: rtl/bitfusion_column_ctrl_if.sv
// bitfusion_column_ctrl_if: job config, activation handshake and column-control bundle.
// master drives start/cfg_*/in_valid (and abort when BFC_ABORT_EN is defined);
// slave (the controller) drives in_ready/in_fire/state/input_bitwidth/sign_*/signal/
// acc_clear/busy/out_valid/done.
interface bitfusion_column_ctrl_if #(parameter int CNT_W = 16);
  logic             start;
  logic [1:0]       cfg_bitwidth;
  logic [3:0]       cfg_sign_x;
  logic [3:0]       cfg_sign_y;
  logic [CNT_W-1:0] cfg_num_vec;
  logic             in_valid;
  logic             in_ready;
  logic             in_fire;
  logic [1:0]       state;
  logic [1:0]       input_bitwidth;
  logic [3:0]       sign_x;
  logic [3:0]       sign_y;
  logic [47:0]      signal;
  logic             acc_clear;
  logic             busy;
  logic             out_valid;
  logic             done;
`ifdef BFC_ABORT_EN
  logic             abort;
`endif
  modport master(
`ifdef BFC_ABORT_EN
    output abort,
`endif
    output start, cfg_bitwidth, cfg_sign_x, cfg_sign_y, cfg_num_vec, in_valid,
    input  in_ready, in_fire, state, input_bitwidth, sign_x, sign_y, signal,
           acc_clear, busy, out_valid, done
  );
  modport slave(
`ifdef BFC_ABORT_EN
    input  abort,
`endif
    input  start, cfg_bitwidth, cfg_sign_x, cfg_sign_y, cfg_num_vec, in_valid,
    output in_ready, in_fire, state, input_bitwidth, sign_x, sign_y, signal,
           acc_clear, busy, out_valid, done
  );
endinterface

// File: rtl/bitfusion_beat_counter.sv
// bitfusion_beat_counter: loadable down-counter that saturates at zero.
// Ports: clk, reset (async active-low), load_i/val_i load, dec_i decrement, cnt_o count, zero_o count==0.
module bitfusion_beat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o  = cnt_q;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/bitfusion_column_ctrl.sv
// bitfusion_column_ctrl: job sequencer for one BitFusion PE column (IDLE/LOAD_W/STREAM/DRAIN/DONE).
// Ports: clk, reset (async active-low), bus (bitfusion_column_ctrl_if.slave).
// Define BFC_ABORT_EN to add bus.abort, which returns any busy state to IDLE silently.
module bitfusion_column_ctrl
  import bitfusion_pkg::*;
#(
  parameter int NUM_PE    = BF_NUM_PE,
  parameter int CNT_W     = 16,
  parameter int WLOAD_LAT = 2
) (
  input logic clk,
  input logic reset,
  bitfusion_column_ctrl_if.slave bus
);
  localparam int DW = $clog2(NUM_PE + 2);
  bfc_fsm_e st_q, st_d;
  logic [1:0] state_q, state_d, bw_q, bw_d;
  logic [3:0] sx_q, sx_d, sy_q, sy_d;
  logic acc_clear_q, acc_clear_d, in_ready_q, in_ready_d, busy_q, busy_d;
  logic out_valid_q, out_valid_d, done_q, done_d;
  logic take, fire, last_beat, kill, vzero, dzero, dload, ddec;
  logic [CNT_W-1:0] vcnt;
  logic [DW-1:0] dcnt;
  assign take      = st_q == S_IDLE && bus.start;
  assign fire      = bus.in_valid & in_ready_q;
  assign last_beat = fire && vcnt == CNT_W'(1);
`ifdef BFC_ABORT_EN
  assign kill = bus.abort && st_q != S_IDLE;
`else
  assign kill = 1'b0;
`endif
  // The drain counter also times LOAD_W: loaded with WLOAD_LAT-1 on start, NUM_PE on the last beat.
  assign dload = take || (st_q == S_STREAM && st_d == S_DRAIN);
  assign ddec  = st_q == S_LOAD_W || st_q == S_DRAIN;
  bitfusion_beat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk(clk), .reset(reset), .load_i(take), .val_i(bus.cfg_num_vec),
    .dec_i(fire), .cnt_o(vcnt), .zero_o(vzero)
  );
  bitfusion_beat_counter #(.W(DW)) u_drain_cnt (
    .clk(clk), .reset(reset), .load_i(dload),
    .val_i(take ? DW'(WLOAD_LAT - 1) : DW'(NUM_PE)),
    .dec_i(ddec), .cnt_o(dcnt), .zero_o(dzero)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) st_q <= S_IDLE;
    else st_q <= st_d;
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE:   st_d = !bus.start ? S_IDLE : bus.cfg_num_vec == '0 ? S_DONE : S_LOAD_W;
      S_LOAD_W: st_d = dzero ? S_STREAM : S_LOAD_W;
      // vzero is a guard so a stream entered with nothing left cannot hang.
      S_STREAM: st_d = (last_beat || vzero) ? S_DRAIN : S_STREAM;
      S_DRAIN:  st_d = dzero ? S_DONE : S_DRAIN;
      default:  st_d = S_IDLE;
    endcase
    if (kill) st_d = S_IDLE;
  end
  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    state_d     = st_d == S_LOAD_W ? BF_ST_LOAD : st_d == S_STREAM ? BF_ST_COMP :
                  st_d == S_DRAIN ? BF_ST_DRAIN : BF_ST_IDLE;
    bw_d        = take ? bus.cfg_bitwidth : bw_q;
    sx_d        = take ? bus.cfg_sign_x : sx_q;
    sy_d        = take ? bus.cfg_sign_y : sy_q;
    acc_clear_d = st_q == S_IDLE && st_d == S_LOAD_W;
    in_ready_d  = st_d == S_STREAM;
    busy_d      = st_d != S_IDLE;
    out_valid_d = st_d == S_DRAIN && dcnt == DW'(1);
    done_d      = st_d == S_DONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= BF_ST_IDLE;
      bw_q        <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      acc_clear_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bw_q        <= bw_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      acc_clear_q <= acc_clear_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  assign bus.in_ready       = in_ready_q;
  assign bus.in_fire        = fire;
  assign bus.state          = state_q;
  assign bus.input_bitwidth = bw_q;
  assign bus.sign_x         = sx_q;
  assign bus.sign_y         = sy_q;
  assign bus.signal         = BF_SIGNAL_LUT[bw_q];
  assign bus.acc_clear      = acc_clear_q;
  assign bus.busy           = busy_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.done           = done_q;
endmodule

// File: tb/tb_bitfusion_column_ctrl.sv
// tb_bitfusion_column_ctrl: directed self-checking bench for bitfusion_column_ctrl.
module tb_bitfusion_column_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_v;
  bitfusion_column_ctrl_if #(.CNT_W(16)) bus();
  bitfusion_column_ctrl #(.NUM_PE(16), .CNT_W(16), .WLOAD_LAT(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  // Expected {state, acc_clear, in_ready, in_fire, busy, out_valid, done} for a job started
  // at cycle 0 whose last beat is accepted at cycle l (NUM_PE=16, WLOAD_LAT=2).
  function automatic logic [7:0] model(int c, int l, logic v);
    logic [1:0] s;
    logic r;
    s = (c >= 1 && c <= 2) ? 2'b01 : (c >= 3 && c <= l) ? 2'b10 :
        (c > l && c <= l + 17) ? 2'b11 : 2'b00;
    r = c >= 3 && c <= l;
    return {s, c == 1, r, r & v, c >= 1 && c <= l + 18, c == l + 17, c == l + 18};
  endfunction
  function automatic logic [7:0] obs();
    return {bus.state, bus.acc_clear, bus.in_ready, bus.in_fire, bus.busy, bus.out_valid, bus.done};
  endfunction
  task automatic idle_inputs();
    bus.start        = 1'b0;
    bus.cfg_bitwidth = 2'd0;
    bus.cfg_sign_x   = 4'h0;
    bus.cfg_sign_y   = 4'h0;
    bus.cfg_num_vec  = 16'd0;
    bus.in_valid     = 1'b0;
`ifdef BFC_ABORT_EN
    bus.abort        = 1'b0;
`endif
  endtask
  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    #1;
    total_cnt++;
    if ({obs(), bus.input_bitwidth, bus.sign_x, bus.sign_y, bus.signal} !== 66'd0)
      $display("FAIL reset_hold got %b sig %h, want all zero", obs(), bus.signal);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({obs(), bus.input_bitwidth, bus.sign_x, bus.sign_y, bus.signal} !== 66'd0)
      $display("FAIL reset_release got %b sig %h, want all zero", obs(), bus.signal);
    else pass_cnt++;
  endtask
  task automatic test_basic();
    for (int c = 0; c <= 26; c++) begin
      @(negedge clk);
      bus.start = (c == 0);
      bus.cfg_bitwidth = 2'd2;
      bus.cfg_sign_x = 4'h3;
      bus.cfg_sign_y = 4'hC;
      bus.cfg_num_vec = 16'd4;
      bus.in_valid = 1'b1;
      #1;
      exp_v = model(c, 6, 1'b1);
      total_cnt++;
      if (obs() !== exp_v) $display("FAIL basic c=%0d got %b want %b", c, obs(), exp_v);
      else pass_cnt++;
      if (c == 4) begin
        total_cnt++;
        if ({bus.input_bitwidth, bus.sign_x, bus.sign_y, bus.signal} !== {2'd2, 4'h3, 4'hC, 48'hFFFF_FFFF_FFFF})
          $display("FAIL basic_cfg got bw %0d sx %h sy %h sig %h want 2 3 c ffffffffffff",
                   bus.input_bitwidth, bus.sign_x, bus.sign_y, bus.signal);
        else pass_cnt++;
      end
    end
    idle_inputs();
  endtask
  task automatic test_bubbles();
    int fires = 0;
    logic v;
    for (int c = 0; c <= 27; c++) begin
      @(negedge clk);
      v = (c == 3 || c == 6 || c == 7);
      bus.start = (c == 0);
      bus.cfg_bitwidth = 2'd1;
      bus.cfg_num_vec = 16'd3;
      bus.in_valid = v;
      #1;
      if (bus.in_fire === 1'b1) fires++;
      exp_v = model(c, 7, v);
      total_cnt++;
      if (obs() !== exp_v) $display("FAIL bubbles c=%0d got %b want %b", c, obs(), exp_v);
      else pass_cnt++;
    end
    total_cnt++;
    if (fires != 3) $display("FAIL bubbles_fire_count got %0d want 3", fires);
    else pass_cnt++;
    idle_inputs();
  endtask
  task automatic test_zero_len();
    logic [1:0] bw;
    logic [47:0] sig;
    for (int k = 0; k < 2; k++) begin
      bw = (k == 0) ? 2'd1 : 2'd3;
      sig = (k == 0) ? 48'h5555_5555_5555 : 48'hFFFF_FFFF_FFFF;
      for (int c = 0; c <= 3; c++) begin
        @(negedge clk);
        bus.start = (c == 0);
        bus.cfg_bitwidth = bw;
        bus.cfg_num_vec = 16'd0;
        #1;
        exp_v = (c == 1) ? 8'b0000_0101 : 8'b0000_0000;
        total_cnt++;
        if (obs() !== exp_v) $display("FAIL zero_len bw=%0d c=%0d got %b want %b", bw, c, obs(), exp_v);
        else pass_cnt++;
        if (c == 2) begin
          total_cnt++;
          if (bus.signal !== sig) $display("FAIL zero_len_signal bw=%0d got %h want %h", bw, bus.signal, sig);
          else pass_cnt++;
        end
      end
    end
    idle_inputs();
  endtask
  task automatic test_config_isolation();
    for (int c = 0; c <= 26; c++) begin
      @(negedge clk);
      bus.start = (c == 0 || c == 4);
      bus.cfg_bitwidth = (c < 4) ? 2'd2 : 2'd0;
      bus.cfg_sign_x = (c < 4) ? 4'hA : 4'h0;
      bus.cfg_sign_y = (c < 4) ? 4'h5 : 4'hF;
      bus.cfg_num_vec = (c < 4) ? 16'd4 : 16'd9;
      bus.in_valid = 1'b1;
      #1;
      exp_v = model(c, 6, 1'b1);
      total_cnt++;
      if (obs() !== exp_v) $display("FAIL cfg_iso c=%0d got %b want %b", c, obs(), exp_v);
      else pass_cnt++;
      if (c >= 1) begin
        total_cnt++;
        if ({bus.input_bitwidth, bus.sign_x, bus.sign_y, bus.signal} !== {2'd2, 4'hA, 4'h5, 48'hFFFF_FFFF_FFFF})
          $display("FAIL cfg_iso_hold c=%0d got bw %0d sx %h sy %h sig %h want 2 a 5 ffffffffffff",
                   c, bus.input_bitwidth, bus.sign_x, bus.sign_y, bus.signal);
        else pass_cnt++;
      end
    end
    idle_inputs();
  endtask
  task automatic test_reset_mid_job();
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      bus.start = (c == 0);
      bus.cfg_bitwidth = 2'd1;
      bus.cfg_sign_x = 4'h7;
      bus.cfg_num_vec = 16'd2;
      bus.in_valid = 1'b1;
      #1;
      exp_v = model(c, 4, 1'b1);
      total_cnt++;
      if (obs() !== exp_v) $display("FAIL rst_job c=%0d got %b want %b", c, obs(), exp_v);
      else pass_cnt++;
    end
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({obs(), bus.input_bitwidth, bus.sign_x, bus.sign_y, bus.signal} !== 66'd0)
      $display("FAIL rst_async got %b sig %h want all zero", obs(), bus.signal);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (obs() !== 8'd0) $display("FAIL rst_held got %b want 0", obs());
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      bus.start = (c == 0);
      bus.cfg_num_vec = 16'd1;
      bus.in_valid = 1'b1;
      #1;
      exp_v = model(c, 3, 1'b1);
      total_cnt++;
      if (obs() !== exp_v) $display("FAIL rst_rejob c=%0d got %b want %b", c, obs(), exp_v);
      else pass_cnt++;
    end
    idle_inputs();
  endtask
`ifdef BFC_ABORT_EN
  task automatic test_abort();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      bus.start = (c == 0);
      bus.cfg_num_vec = 16'd4;
      bus.in_valid = 1'b1;
      bus.abort = (c == 4);
      #1;
      exp_v = (c <= 4) ? model(c, 6, 1'b1) : 8'd0;
      total_cnt++;
      if (obs() !== exp_v) $display("FAIL abort c=%0d got %b want %b", c, obs(), exp_v);
      else pass_cnt++;
    end
    for (int c = 0; c <= 26; c++) begin
      @(negedge clk);
      bus.start = (c == 0);
      bus.abort = (c == 0);
      bus.cfg_num_vec = 16'd4;
      bus.in_valid = 1'b1;
      #1;
      exp_v = model(c, 6, 1'b1);
      total_cnt++;
      if (obs() !== exp_v) $display("FAIL abort_rejob c=%0d got %b want %b", c, obs(), exp_v);
      else pass_cnt++;
    end
    idle_inputs();
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_zero_len();
    test_config_isolation();
    test_reset_mid_job();
`ifdef BFC_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
